vga_rect_fill: RTL and testbench

- Pixel-generation stage directly upstream of the VGA adapter. Turns a rectangle-fill command from the CPU or control logic into a raster stream of x/y/colour/plot writes, at most one pixel per clock.
- Targets the 160x120 framebuffer. Clips every rectangle to the screen.
- Outputs connect directly to the adapter's x, y, colour and plot inputs.

---
 rtl/vga_rect_fill.sv | 151 +++++++++++++++
 tb/tb_vga_rect_fill.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// Rectangle fill raster generator for the 160x120 VGA adapter.
// Clips each command to the screen and emits at most one pixel write per clock.
module vga_rect_fill #(
    parameter int unsigned X_WIDTH      = 8,
    parameter int unsigned Y_WIDTH      = 7,
    parameter int unsigned COLOUR_WIDTH = 3,
    parameter int unsigned X_MAX        = 159,
    parameter int unsigned Y_MAX        = 119
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [X_WIDTH-1:0]      cmd_x0,
    input  logic [Y_WIDTH-1:0]      cmd_y0,
    input  logic [X_WIDTH-1:0]      cmd_w,
    input  logic [Y_WIDTH-1:0]      cmd_h,
    input  logic [COLOUR_WIDTH-1:0] cmd_colour,
    input  logic                    hold,
    output logic [X_WIDTH-1:0]      x,
    output logic [Y_WIDTH-1:0]      y,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam logic [X_WIDTH:0]   XLim  = X_MAX[X_WIDTH:0];
    localparam logic [Y_WIDTH:0]   YLim  = Y_MAX[Y_WIDTH:0];
    localparam logic [X_WIDTH:0]   XOne  = 1;
    localparam logic [Y_WIDTH:0]   YOne  = 1;
    localparam logic [X_WIDTH-1:0] XStep = 1;
    localparam logic [Y_WIDTH-1:0] YStep = 1;

    typedef enum logic [1:0] {StIdle, StClip, StDraw, StDone} state_e;

    state_e state_q, state_d;

    logic [X_WIDTH-1:0]      x0_q, w_q, x1_q, x_q;
    logic [Y_WIDTH-1:0]      y0_q, h_q, y1_q, y_q;
    logic [COLOUR_WIDTH-1:0] colour_q;
    logic                    busy_q, done_q;

    logic                    accept;
    logic [X_WIDTH:0]        x_end;
    logic [Y_WIDTH:0]        y_end;
    logic [X_WIDTH-1:0]      x_last;
    logic [Y_WIDTH-1:0]      y_last;
    logic                    empty;
    logic                    last_pix;

    assign accept = cmd_valid && cmd_ready;

    // One extra bit on the end sums so a rectangle running off the edge cannot wrap.
    always_comb begin
        x_end  = {1'b0, x0_q} + {1'b0, w_q} - XOne;
        y_end  = {1'b0, y0_q} + {1'b0, h_q} - YOne;
        x_last = (x_end > XLim) ? XLim[X_WIDTH-1:0] : x_end[X_WIDTH-1:0];
        y_last = (y_end > YLim) ? YLim[Y_WIDTH-1:0] : y_end[Y_WIDTH-1:0];
        empty  = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x0_q} > XLim) || ({1'b0, y0_q} > YLim);
    end

    assign last_pix = (x_q >= x1_q) && (y_q >= y1_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StClip;
                end
            end
            StClip: begin
                state_d = empty ? StDone : StDraw;
            end
            StDraw: begin
                if (!hold && last_pix) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The strobe is gated by hold in the same cycle so a paused cycle never writes.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        plot      = (state_q == StDraw) && !hold;
        x         = x_q;
        y         = y_q;
        colour    = colour_q;
        busy      = busy_q;
        done      = done_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != StIdle);
            done_q <= (state_d == StDone);
            if (accept) begin
                x0_q     <= cmd_x0;
                y0_q     <= cmd_y0;
                w_q      <= cmd_w;
                h_q      <= cmd_h;
                colour_q <= cmd_colour;
            end
            if (state_q == StClip && !empty) begin
                x1_q <= x_last;
                y1_q <= y_last;
                x_q  <= x0_q;
                y_q  <= y0_q;
            end
            // Counters only move on a cycle that actually wrote; the final pixel stays put.
            if (state_q == StDraw && !hold && !last_pix) begin
                if (x_q < x1_q) begin
                    x_q <= x_q + XStep;
                end else begin
                    x_q <= x0_q;
                    y_q <= y_q + YStep;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: vector table, directed corner cases and
// randomised commands with random hold, checked against a pixel-list reference model.
module tb_vga_rect_fill;

    localparam int XMAX = 159;
    localparam int YMAX = 119;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0;
    logic [6:0] cmd_y0;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [2:0] cmd_colour;
    logic       hold;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    vga_rect_fill dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .hold       (hold),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        int col;
        int n;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    pix_t got_q[$];
    int   acc_q[$];
    int   done_q[$];
    bit   hold_hist [0:65535];
    bit   rand_hold = 1'b0;
    int   hold_from = -10;
    int   hold_to   = -10;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // hold driver: directed window plus optional random stalls
    initial begin
        hold = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            hold = (cyc >= hold_from && cyc <= hold_to) ||
                   (rand_hold && ($urandom_range(0, 3) == 0));
        end
    end

    // Monitor: records accepts, pixel writes and done pulses per cycle
    initial begin
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            hold_hist[cyc] = hold;
            if (resetn && cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (plot) begin
                got_q.push_back('{int'(x), int'(y), int'(colour), cyc});
                check("plot_in_range", int'(x <= 8'd159 && y <= 7'd119), 1);
                check("plot_while_hold", int'(hold), 0);
            end
            if (done) begin
                done_q.push_back(cyc);
                check("done_busy", int'(busy), 1);
                check("done_plot", int'(plot), 0);
                check("done_ready", int'(cmd_ready), 0);
            end
            if (prev_done) begin
                check("after_done_ready", int'(cmd_ready), 1);
                check("after_done_busy", int'(busy), 0);
                check("after_done_done", int'(done), 0);
            end
            prev_done = done;
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(posedge clock);
        #1;
        while (!cmd_ready && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", t);
        end
    endtask

    task automatic issue_cmd(input int x0, input int y0, input int w, input int h,
                             input int col);
        wait_ready();
        got_q.delete();
        acc_q.delete();
        done_q.delete();
        cmd_x0     = 8'(x0);
        cmd_y0     = 7'(y0);
        cmd_w      = 8'(w);
        cmd_h      = 7'(h);
        cmd_colour = 3'(col);
        cmd_valid  = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid  = 1'b0;
        // Scramble the command bus; the latched command must be unaffected.
        cmd_x0     = 8'($urandom);
        cmd_y0     = 7'($urandom);
        cmd_w      = 8'($urandom);
        cmd_h      = 7'($urandom);
        cmd_colour = 3'($urandom);
    endtask

    // Reference: clipped pixel list in raster order; each non-held draw cycle
    // starting two cycles after accept writes the next pixel, done follows the last.
    task automatic finish_cmd(input string name, input int x0, input int y0, input int w,
                              input int h, input int col, input int exp_n);
        pix_t exp_q[$];
        int   t = 0;
        int   c;
        while (done_q.size() == 0 && t < 3000) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (done_q.size() == 0 || acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=%0d accepts=%0d after %0d cycles",
                     name, done_q.size(), acc_q.size(), t);
            return;
        end
        for (int yy = y0; yy < y0 + h; yy++) begin
            for (int xx = x0; xx < x0 + w; xx++) begin
                if (xx <= XMAX && yy <= YMAX) exp_q.push_back('{xx, yy, col, 0});
            end
        end
        c = acc_q[0] + 2;
        foreach (exp_q[i]) begin
            while (hold_hist[c]) c++;
            exp_q[i].cyc = c;
            c++;
        end
        check({name, "_done_cycle"}, done_q[0], c);
        check({name, "_pixel_count"}, got_q.size(), exp_q.size());
        if (exp_n >= 0) check({name, "_table_count"}, got_q.size(), exp_n);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_px%0d_x", name, i), got_q[i].x, exp_q[i].x);
            check($sformatf("%s_px%0d_y", name, i), got_q[i].y, exp_q[i].y);
            check($sformatf("%s_px%0d_col", name, i), got_q[i].c, exp_q[i].c);
            check($sformatf("%s_px%0d_cyc", name, i), got_q[i].cyc, exp_q[i].cyc);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t;
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_x0     = '0;
        cmd_y0     = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;

        vecs[0] = '{10, 20, 2, 2, 5, 4};
        vecs[1] = '{158, 119, 5, 3, 2, 2};
        vecs[2] = '{0, 0, 0, 5, 1, 0};
        vecs[3] = '{200, 10, 4, 4, 3, 0};
        vecs[4] = '{5, 120, 3, 3, 4, 0};
        vecs[5] = '{3, 4, 1, 0, 1, 0};
        vecs[6] = '{159, 119, 1, 1, 5, 1};
        vecs[7] = '{0, 0, 160, 1, 7, 160};
        vecs[8] = '{150, 110, 255, 127, 6, 100};
        vecs[9] = '{255, 127, 255, 127, 2, 0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        #2 resetn = 1'b1;
        @(negedge clock);
        check("post_rst_ready", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            issue_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].col);
            finish_cmd($sformatf("vec%0d", i), vecs[i].x0, vecs[i].y0, vecs[i].w,
                       vecs[i].h, vecs[i].col, vecs[i].n);
        end

        // Hold: 4x1 at origin, stall three cycles once x=1 is pending.
        issue_cmd(0, 0, 4, 1, 3);
        hold_from = cyc + 2;
        hold_to   = cyc + 4;
        repeat (2) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_plot", int'(plot), 0);
            check("hold_x", int'(x), 1);
        end
        finish_cmd("hold", 0, 0, 4, 1, 3, 4);
        if (done_q.size() > 0 && acc_q.size() > 0)
            check("hold_done_delay", done_q[0] - acc_q[0], 9);
        hold_from = -10;
        hold_to   = -10;

        // Reset in the middle of a 10x10 fill.
        issue_cmd(20, 30, 10, 10, 6);
        t = 0;
        while (got_q.size() < 15 && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("mid_reset_reached_15", int'(got_q.size() >= 15), 1);
        #1 resetn = 1'b0;
        #1;
        check("mid_reset_plot", int'(plot), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(done), 0);
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        check("mid_reset_ready", int'(cmd_ready), 1);
        check("mid_reset_no_done", done_q.size(), 0);
        issue_cmd(5, 5, 1, 1, 3);
        finish_cmd("after_reset", 5, 5, 1, 1, 3, 1);

        // Back-to-back: valid held high across two 1x1 commands.
        wait_ready();
        got_q.delete();
        acc_q.delete();
        done_q.delete();
        cmd_x0     = 8'd1;
        cmd_y0     = 7'd1;
        cmd_w      = 8'd1;
        cmd_h      = 7'd1;
        cmd_colour = 3'd1;
        cmd_valid  = 1'b1;
        k = cyc;
        @(posedge clock);
        #1;
        cmd_x0     = 8'd2;
        cmd_y0     = 7'd2;
        cmd_colour = 3'd2;
        t = 0;
        while (acc_q.size() < 2 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        cmd_valid = 1'b0;
        t = 0;
        while (done_q.size() < 2 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("b2b_accepts", acc_q.size(), 2);
        check("b2b_dones", done_q.size(), 2);
        check("b2b_pixels", got_q.size(), 2);
        if (acc_q.size() >= 2 && done_q.size() >= 2 && got_q.size() >= 2) begin
            check("b2b_first_accept", acc_q[0], k);
            check("b2b_first_done", done_q[0], k + 3);
            check("b2b_second_accept", acc_q[1], done_q[0] + 1);
            check("b2b_second_done", done_q[1], acc_q[1] + 3);
            check("b2b_p0_x", got_q[0].x, 1);
            check("b2b_p0_col", got_q[0].c, 1);
            check("b2b_p1_x", got_q[1].x, 2);
            check("b2b_p1_y", got_q[1].y, 2);
            check("b2b_p1_col", got_q[1].c, 2);
        end

        // Random commands with random hold stalls.
        rand_hold = 1'b1;
        for (int i = 0; i < 25; i++) begin
            int rx0, ry0, rw, rh, rc;
            rx0 = $urandom_range(0, 175);
            ry0 = $urandom_range(0, 127);
            rw  = $urandom_range(0, 24);
            rh  = $urandom_range(0, 12);
            rc  = $urandom_range(0, 7);
            issue_cmd(rx0, ry0, rw, rh, rc);
            finish_cmd($sformatf("rnd%0d", i), rx0, ry0, rw, rh, rc, -1);
        end
        rand_hold = 1'b0;

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
